// File: rtl/scholar_mem_responder_pkg.sv
// Shared types and helpers for the memory responder.
// Holds the port FSM state, latency counter width and word-offset math.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    localparam int unsigned MAX_LATENCY = 255;
    localparam int unsigned LAT_WIDTH   = $clog2(MAX_LATENCY + 1);

    function automatic logic [63:0] word_offset(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned shift
    );
        return (addr - base) >> shift;
    endfunction

endpackage

// File: rtl/scholar_mem_responder_port.sv
// Per-port latency FSM: captures a request payload and fires after Latency cycles.
// Dropping the request while waiting abandons the access.
module mem_resp_port
    import mem_resp_pkg::*;
#(
    parameter int unsigned Latency      = 1,
    parameter int unsigned PayloadWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic [PayloadWidth-1:0] payload_i,
    output logic                    accept_o,
    output logic                    fire_o,
    output logic [PayloadWidth-1:0] payload_o
);

    localparam logic [LAT_WIDTH-1:0] CntInit = LAT_WIDTH'(Latency - 1);

    resp_state_e             state_q, state_d;
    logic [LAT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [PayloadWidth-1:0] payload_q, payload_d;
    logic                    accept, fire;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        accept    = 1'b0;
        fire      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    accept    = 1'b1;
                    payload_d = payload_i;
                    cnt_d     = CntInit;
                    if (Latency == 1) begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (cnt_q == LAT_WIDTH'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_WIDTH'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
        end
    end

    // With Latency 1 the access fires on its accept edge, before capture lands.
    assign payload_o = (state_q == IDLE) ? payload_i : payload_q;
    assign accept_o  = accept && !rst_i;
    assign fire_o    = fire && !rst_i;

endmodule

// File: rtl/scholar_mem_responder.sv
// Unified word memory answering the core's I and D ports with programmable latency.
// Reads sample the array before a same-edge write, so I sees pre-write data.
module scholar_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          MemDepth  = 2**14,
    parameter int unsigned          ILatency  = 1,
    parameter int unsigned          DLatency  = 1,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   i_m_addr_i,
    input  logic                   i_m_rden_i,
    output logic [31:0]            i_m_rdata_o,
    output logic                   i_m_hit_o,
    input  logic [AddrWidth-1:0]   d_m_addr_i,
    input  logic                   d_m_rden_i,
    input  logic                   d_m_wren_i,
    input  logic [DataWidth-1:0]   d_m_wdata_i,
    input  logic [DataWidth/8-1:0] d_m_wmask_i,
    output logic [DataWidth-1:0]   d_m_rdata_o,
    output logic                   d_m_hit_o,
    output logic                   d_m_err_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ByteShift = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(MemDepth);
    localparam int unsigned DPayWidth = 1 + StrbWidth + DataWidth + AddrWidth;

    logic [DataWidth-1:0] mem_q [MemDepth];

    logic                 i_accept, i_fire;
    logic [AddrWidth-1:0] i_addr;
    logic                 d_accept, d_fire;
    logic [DPayWidth-1:0] d_payload_in, d_payload;

    logic                 d_we;
    logic [StrbWidth-1:0] d_wmask;
    logic [DataWidth-1:0] d_wdata;
    logic [AddrWidth-1:0] d_addr;

    mem_resp_port #(
        .Latency      (ILatency),
        .PayloadWidth (AddrWidth)
    ) u_i_port (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (i_m_rden_i),
        .payload_i (i_m_addr_i),
        .accept_o  (i_accept),
        .fire_o    (i_fire),
        .payload_o (i_addr)
    );

    assign d_payload_in = {d_m_wren_i, d_m_wmask_i, d_m_wdata_i, d_m_addr_i};

    mem_resp_port #(
        .Latency      (DLatency),
        .PayloadWidth (DPayWidth)
    ) u_d_port (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (d_m_rden_i || d_m_wren_i),
        .payload_i (d_payload_in),
        .accept_o  (d_accept),
        .fire_o    (d_fire),
        .payload_o (d_payload)
    );

    assign {d_we, d_wmask, d_wdata, d_addr} = d_payload;

    logic [63:0]          i_off, d_off;
    logic                 i_oor, d_oor;
    logic [IdxWidth-1:0]  i_idx, d_idx;
    logic [DataWidth-1:0] i_raw, d_raw, d_merged;
    logic [31:0]          i_word;
    logic                 mem_we;

    assign i_off = word_offset(64'(i_addr), 64'(BaseAddr), ByteShift);
    assign d_off = word_offset(64'(d_addr), 64'(BaseAddr), ByteShift);
    assign i_oor = (i_addr < BaseAddr) || (i_off >= 64'(MemDepth));
    assign d_oor = (d_addr < BaseAddr) || (d_off >= 64'(MemDepth));
    assign i_idx = i_off[IdxWidth-1:0];
    assign d_idx = d_off[IdxWidth-1:0];
    assign i_raw = mem_q[i_idx];
    assign d_raw = mem_q[d_idx];

    if (DataWidth == 64) begin : g_rv64
        assign i_word = i_addr[2] ? i_raw[63:32] : i_raw[31:0];
    end else begin : g_rv32
        assign i_word = i_raw[31:0];
    end

    always_comb begin
        d_merged = d_raw;
        for (int b = 0; b < StrbWidth; b++) begin
            if (d_wmask[b]) begin
                d_merged[b*8 +: 8] = d_wdata[b*8 +: 8];
            end
        end
    end

    assign mem_we = d_fire && d_we && !d_oor;

    logic                 i_hit_q, i_hit_d;
    logic [31:0]          i_rdata_q, i_rdata_d;
    logic                 d_hit_q, d_hit_d;
    logic                 d_err_q, d_err_d;
    logic [DataWidth-1:0] d_rdata_q, d_rdata_d;

    always_comb begin
        i_hit_d   = i_fire;
        i_rdata_d = '0;
        d_hit_d   = d_fire;
        d_err_d   = d_fire && d_oor;
        d_rdata_d = '0;
        if (i_fire && !i_oor) begin
            i_rdata_d = i_word;
        end
        if (d_fire && !d_oor && !d_we) begin
            d_rdata_d = d_raw;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_hit_q   <= 1'b0;
            i_rdata_q <= '0;
            d_hit_q   <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            i_hit_q   <= i_hit_d;
            i_rdata_q <= i_rdata_d;
            d_hit_q   <= d_hit_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[d_idx] <= d_merged;
        end
    end

    assign i_m_hit_o   = i_hit_q;
    assign i_m_rdata_o = i_rdata_q;
    assign d_m_hit_o   = d_hit_q;
    assign d_m_err_o   = d_err_q;
    assign d_m_rdata_o = d_rdata_q;

`ifndef SYNTHESIS
    rw_exclusive_a: assert property (@(posedge clk_i) disable iff (rst_i)
        d_accept |-> !(d_m_rden_i && d_m_wren_i));
    i_addr_known_a: assert property (@(posedge clk_i) disable iff (rst_i)
        i_accept |-> !$isunknown(i_m_addr_i));
`endif

endmodule

// File: tb/tb_scholar_mem_responder.sv
// Directed bench for scholar_mem_responder (ILatency 3, DLatency 2, 256 words).
// Each task drives one scenario and checks its own hand-computed results.
module tb_scholar_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_rden;
    logic [31:0] i_rdata;
    logic        i_hit;
    logic [31:0] d_addr;
    logic        d_rden;
    logic        d_wren;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_hit;
    logic        d_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scholar_mem_responder #(
        .AddrWidth (32),
        .DataWidth (32),
        .MemDepth  (256),
        .ILatency  (3),
        .DLatency  (2),
        .BaseAddr  (32'h0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .i_m_addr_i  (i_addr),
        .i_m_rden_i  (i_rden),
        .i_m_rdata_o (i_rdata),
        .i_m_hit_o   (i_hit),
        .d_m_addr_i  (d_addr),
        .d_m_rden_i  (d_rden),
        .d_m_wren_i  (d_wren),
        .d_m_wdata_i (d_wdata),
        .d_m_wmask_i (d_wmask),
        .d_m_rdata_o (d_rdata),
        .d_m_hit_o   (d_hit),
        .d_m_err_o   (d_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic i_fetch(input logic [31:0] a, output logic [31:0] data, output int lat);
        lat    = -1;
        data   = '0;
        i_rden = 1'b1;
        i_addr = a;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            step();
            if (i_hit) begin
                lat  = c;
                data = i_rdata;
            end
        end
        i_rden = 1'b0;
        step();
    endtask

    task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] m, output logic [31:0] data,
                            output logic err, output int lat);
        lat     = -1;
        data    = '0;
        err     = 1'b0;
        d_wren  = we;
        d_rden  = !we;
        d_addr  = a;
        d_wdata = wd;
        d_wmask = m;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            step();
            if (d_hit) begin
                lat  = c;
                data = d_rdata;
                err  = d_err;
            end
        end
        d_wren = 1'b0;
        d_rden = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] data;
        int          lat;
        rst    = 1'b1;
        i_rden = 1'b1;
        i_addr = 32'h0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if ({i_hit, d_hit, d_err, i_rdata, d_rdata} !== 67'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got hit=%b/%b err=%b rdata=%h/%h required all 0",
                         i_hit, d_hit, d_err, i_rdata, d_rdata);
            end
        end
        rst = 1'b0;
        i_fetch(32'h0, data, lat);
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL reset_first_hit: got latency %0d required 3", lat);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] data;
        logic        err;
        int          lat;
        d_access(1'b1, 32'h0, 32'h00500093, 4'hF, data, err, lat);
        n_checks++;
        if (lat !== 2 || err !== 1'b0 || data !== 32'h0) begin
            n_fail++;
            $display("FAIL preload_write: got lat=%0d err=%b rdata=%h required 2/0/0", lat, err, data);
        end
        i_fetch(32'h0, data, lat);
        n_checks++;
        if (lat !== 3 || data !== 32'h00500093) begin
            n_fail++;
            $display("FAIL fetch_word0: got lat=%0d data=%h required 3/00500093", lat, data);
        end
        i_fetch(32'h2, data, lat);
        n_checks++;
        if (lat !== 3 || data !== 32'h00500093) begin
            n_fail++;
            $display("FAIL fetch_misaligned: got lat=%0d data=%h required 3/00500093", lat, data);
        end
    endtask

    task automatic test_write_mask();
        logic [31:0] data;
        logic        err;
        int          lat;
        d_access(1'b1, 32'h4, 32'h11223344, 4'hF, data, err, lat);
        d_access(1'b1, 32'h4, 32'hDEADBEEF, 4'b0101, data, err, lat);
        d_access(1'b0, 32'h4, 32'h0, 4'h0, data, err, lat);
        n_checks++;
        if (lat !== 2 || err !== 1'b0 || data !== 32'h11AD33EF) begin
            n_fail++;
            $display("FAIL masked_write: got lat=%0d err=%b data=%h required 2/0/11ad33ef", lat, err, data);
        end
        i_fetch(32'h4, data, lat);
        n_checks++;
        if (data !== 32'h11AD33EF) begin
            n_fail++;
            $display("FAIL fetch_masked: got %h required 11ad33ef", data);
        end
    endtask

    task automatic test_abort();
        logic [31:0] data;
        logic        err;
        int          lat;
        int          hits;
        hits   = 0;
        i_rden = 1'b1;
        i_addr = 32'h0;
        step();
        step();
        if (i_hit) hits++;
        i_rden = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (i_hit) hits++;
        end
        n_checks++;
        if (hits !== 0) begin
            n_fail++;
            $display("FAIL i_abort: got %0d hits required 0", hits);
        end
        i_fetch(32'h4, data, lat);
        n_checks++;
        if (lat !== 3 || data !== 32'h11AD33EF) begin
            n_fail++;
            $display("FAIL after_abort: got lat=%0d data=%h required 3/11ad33ef", lat, data);
        end
        d_access(1'b1, 32'h8, 32'h0, 4'hF, data, err, lat);
        hits    = 0;
        d_wren  = 1'b1;
        d_addr  = 32'h8;
        d_wdata = 32'hCAFEF00D;
        d_wmask = 4'hF;
        step();
        d_wren = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (d_hit) hits++;
        end
        d_access(1'b0, 32'h8, 32'h0, 4'h0, data, err, lat);
        n_checks++;
        if (hits !== 0 || data !== 32'h0) begin
            n_fail++;
            $display("FAIL d_abort: got hits=%0d word=%h required 0/00000000", hits, data);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] data;
        logic        err;
        int          lat;
        int          hits;
        d_access(1'b1, 32'hC, 32'h0, 4'hF, data, err, lat);
        hits    = 0;
        d_wren  = 1'b1;
        d_addr  = 32'hC;
        d_wdata = 32'h55555555;
        d_wmask = 4'hF;
        step();
        rst = 1'b1;
        step();
        if (d_hit) hits++;
        rst    = 1'b0;
        d_wren = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (d_hit) hits++;
        end
        d_access(1'b0, 32'hC, 32'h0, 4'h0, data, err, lat);
        n_checks++;
        if (hits !== 0 || data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got hits=%0d word=%h required 0/00000000", hits, data);
        end
    endtask

    task automatic test_capture();
        logic [31:0] data;
        i_rden = 1'b1;
        i_addr = 32'h0;
        step();
        i_addr = 32'h4;
        step();
        step();
        data = i_rdata;
        n_checks++;
        if (i_hit !== 1'b1 || data !== 32'h00500093) begin
            n_fail++;
            $display("FAIL addr_capture: got hit=%b data=%h required 1/00500093", i_hit, data);
        end
        i_rden = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen;
        seen   = '0;
        i_rden = 1'b1;
        i_addr = 32'h0;
        for (int c = 0; c < 8; c++) begin
            step();
            seen[c] = i_hit;
        end
        i_rden = 1'b0;
        step();
        step();
        n_checks++;
        if (seen !== 8'b0100_0100) begin
            n_fail++;
            $display("FAIL back_to_back: got hit pattern %b required 01000100", seen);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] data;
        logic        err;
        int          lat;
        d_access(1'b1, 32'h40, 32'h0, 4'hF, data, err, lat);
        i_rden = 1'b1;
        i_addr = 32'h40;
        step();
        d_wren  = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hFFFFFFFF;
        d_wmask = 4'hF;
        step();
        step();
        n_checks++;
        if (i_hit !== 1'b1 || d_hit !== 1'b1 || i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL same_cycle: got ihit=%b dhit=%b idata=%h required 1/1/00000000",
                     i_hit, d_hit, i_rdata);
        end
        i_rden = 1'b0;
        d_wren = 1'b0;
        step();
        i_fetch(32'h40, data, lat);
        n_checks++;
        if (data !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL refetch_new: got %h required ffffffff", data);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] data;
        logic        err;
        int          lat;
        d_access(1'b0, 32'h400, 32'h0, 4'h0, data, err, lat);
        n_checks++;
        if (lat !== 2 || err !== 1'b1 || data !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: got lat=%0d err=%b data=%h required 2/1/0", lat, err, data);
        end
        d_access(1'b1, 32'h400, 32'h12345678, 4'hF, data, err, lat);
        n_checks++;
        if (lat !== 2 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write: got lat=%0d err=%b required 2/1", lat, err);
        end
        d_access(1'b0, 32'h0, 32'h0, 4'h0, data, err, lat);
        n_checks++;
        if (err !== 1'b0 || data !== 32'h00500093) begin
            n_fail++;
            $display("FAIL oor_unchanged: got err=%b data=%h required 0/00500093", err, data);
        end
        d_access(1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, data, err, lat);
        d_access(1'b0, 32'h3FC, 32'h0, 4'h0, data, err, lat);
        n_checks++;
        if (err !== 1'b0 || data !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL last_word: got err=%b data=%h required 0/a5a5a5a5", err, data);
        end
        i_fetch(32'h400, data, lat);
        n_checks++;
        if (lat !== 3 || data !== 32'h0) begin
            n_fail++;
            $display("FAIL i_oor: got lat=%0d data=%h required 3/00000000", lat, data);
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_addr  = '0;
        i_rden  = 1'b0;
        d_addr  = '0;
        d_rden  = 1'b0;
        d_wren  = 1'b0;
        d_wdata = '0;
        d_wmask = '0;
        test_reset();
        test_fetch();
        test_write_mask();
        test_abort();
        test_reset_mid_wait();
        test_capture();
        test_back_to_back();
        test_same_cycle();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
